// File: rtl/uart_rx_fifo_pkg.sv
// Shared definitions for the UART receiver: state encoding and parameter defaults.
package uart_pkg;

    localparam int OVERSAMPLE_DEF = 16;
    localparam int FIFO_DEPTH_DEF = 16;

    typedef enum logic [2:0] {
        RX_IDLE      = 3'd0,
        RX_START     = 3'd1,
        RX_DATA      = 3'd2,
        RX_STOP      = 3'd3,
        RX_WAIT_IDLE = 3'd4
    } rx_state_t;

endpackage

// File: rtl/uart_rx_fifo_sync_fifo.sv
// Synchronous FIFO with a registered head word; a push while full is dropped
// unless a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         in_data,
    input  logic                     push,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     drop
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    next_rd;
    logic [CW-1:0]    next_count;
    logic             full;
    logic             do_pop;
    logic             do_push;

    always_comb begin
        full    = (count == CW'(DEPTH));
        do_pop  = out_valid && out_ready;
        do_push = push && (!full || do_pop);
        drop    = push && full && !do_pop;
        next_rd = do_pop ? rd_ptr + AW'(1) : rd_ptr;
        next_count = count;
        if (do_push && !do_pop)
            next_count = count + CW'(1);
        else if (!do_push && do_pop)
            next_count = count - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= in_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            rd_ptr    <= next_rd;
            count     <= next_count;
            out_valid <= (next_count != '0);
            // Head refreshes only when it moves or the FIFO fills from empty;
            // the slot being written this cycle is not yet in mem.
            if ((do_pop || !out_valid) && next_count != '0)
                out_data <= (do_push && next_rd == wr_ptr) ? in_data : mem[next_rd];
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with oversampled bit timing, sticky error flags and a
// receive FIFO.
//
// state        | meaning
// RX_IDLE      | line idle, waiting for rx_s low
// RX_START     | half-bit check that the start bit is real
// RX_DATA      | sampling 8 data bits at bit centres, LSB first
// RX_STOP      | sampling stop bit; push byte or flag framing error
// RX_WAIT_IDLE | after framing error, wait for line to return high
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [15:0]                 baud_div,
    input  logic                        rxd,
    output logic [7:0]                  out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [$clog2(FIFO_DEPTH):0] count,
    output logic                        frame_err,
    output logic                        overrun,
    input  logic                        clr_err
);

    localparam int OW = $clog2(OVERSAMPLE);

    rx_state_t   state;
    logic        sync1;
    logic        rx_s;
    logic [15:0] tick_cnt;
    logic [15:0] div_q;
    logic        tick;
    logic [OW-1:0] os_cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shift;
    logic        half_tc;
    logic        bit_tc;
    logic        push;
    logic        frame_evt;
    logic        drop;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            sync1 <= rxd;
            rx_s  <= sync1;
        end
    end

    // div_q holds the period in use so a new baud_div only applies after a wrap.
    assign tick = (tick_cnt == div_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt <= '0;
            div_q    <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
            div_q    <= baud_div;
        end else begin
            tick_cnt <= tick_cnt + 16'd1;
        end
    end

    assign half_tc   = tick && (os_cnt == OW'(OVERSAMPLE/2 - 1));
    assign bit_tc    = tick && (os_cnt == OW'(OVERSAMPLE - 1));
    assign push      = (state == RX_STOP) && bit_tc && rx_s;
    assign frame_evt = (state == RX_STOP) && bit_tc && !rx_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RX_IDLE;
            os_cnt    <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (clr_err) begin
                frame_err <= 1'b0;
                overrun   <= 1'b0;
            end
            if (frame_evt)
                frame_err <= 1'b1;
            if (drop)
                overrun <= 1'b1;

            case (state)
                RX_IDLE: begin
                    if (!rx_s) begin
                        state  <= RX_START;
                        os_cnt <= '0;
                    end
                end
                RX_START: begin
                    if (half_tc) begin
                        os_cnt  <= '0;
                        bit_idx <= '0;
                        state   <= rx_s ? RX_IDLE : RX_DATA;
                    end else if (tick) begin
                        os_cnt <= os_cnt + OW'(1);
                    end
                end
                RX_DATA: begin
                    if (bit_tc) begin
                        shift  <= {rx_s, shift[7:1]};
                        os_cnt <= '0;
                        if (bit_idx == 3'd7)
                            state <= RX_STOP;
                        else
                            bit_idx <= bit_idx + 3'd1;
                    end else if (tick) begin
                        os_cnt <= os_cnt + OW'(1);
                    end
                end
                RX_STOP: begin
                    if (bit_tc) begin
                        os_cnt <= '0;
                        state  <= rx_s ? RX_IDLE : RX_WAIT_IDLE;
                    end else if (tick) begin
                        os_cnt <= os_cnt + OW'(1);
                    end
                end
                RX_WAIT_IDLE: begin
                    if (rx_s)
                        state <= RX_IDLE;
                end
                default: state <= RX_IDLE;
            endcase
        end
    end

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .in_data   (shift),
        .push      (push),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count),
        .drop      (drop)
    );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed scenarios plus randomized byte bursts for uart_rx_fifo, checked
// against a queue model of the receive FIFO.
module tb_uart_rx_fifo;
    import uart_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] baud_div;
    logic        rxd;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  count;
    logic        frame_err;
    logic        overrun;
    logic        clr_err;

    int tests = 0;
    int fails = 0;
    int bit_t = 8680;
    logic [7:0] exp_q [$];

    always #5 clk = ~clk;

    uart_rx_fifo dut (
        .clk       (clk),
        .rst       (rst),
        .baud_div  (baud_div),
        .rxd       (rxd),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count),
        .frame_err (frame_err),
        .overrun   (overrun),
        .clr_err   (clr_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop_bit);
        rxd = 1'b0;
        #(bit_t);
        for (int i = 0; i < 8; i++) begin
            rxd = d[i];
            #(bit_t);
        end
        rxd = stop_bit;
        #(bit_t);
        rxd = 1'b1;
    endtask

    task automatic idle_bits(input int n);
        rxd = 1'b1;
        #(n * bit_t);
    endtask

    task automatic pop_expect(input logic [7:0] e, input string tag);
        @(negedge clk);
        check({tag, "_valid"}, 32'(out_valid), 32'(1));
        check({tag, "_data"}, 32'(out_data), 32'(e));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        int  k;
        int  n;
        logic exp_ovr;

        rst = 1'b1; rxd = 1'b1; out_ready = 1'b0; clr_err = 1'b0; baud_div = 16'd53;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("rst_count", 32'(count), 32'(0));
        check("rst_valid", 32'(out_valid), 32'(0));
        check("rst_data", 32'(out_data), 32'(0));
        check("rst_ferr", 32'(frame_err), 32'(0));
        check("rst_ovr", 32'(overrun), 32'(0));
        rst = 1'b0;

        // Scenario 1: one byte at real 115200 baud timing
        idle_bits(1);
        send_byte(8'h37, 1'b1);
        idle_bits(1);
        @(negedge clk);
        check("s1_valid", 32'(out_valid), 32'(1));
        check("s1_data", 32'(out_data), 32'(8'h37));
        check("s1_count", 32'(count), 32'(1));
        check("s1_ferr", 32'(frame_err), 32'(0));
        check("s1_ovr", 32'(overrun), 32'(0));
        pop_expect(8'h37, "s1_pop");
        check("s1_empty", 32'(count), 32'(0));

        // Fast bit rate for the rest: 2 cycles per tick, 32 cycles per bit
        baud_div = 16'd1;
        bit_t = 320;
        #2000;

        // Scenario 2: start glitch shorter than half a bit
        @(negedge clk);
        rxd = 1'b0;
        #60;
        rxd = 1'b1;
        #(2 * bit_t);
        @(negedge clk);
        check("s2_state", 32'(dut.state), 32'(RX_IDLE));
        check("s2_count", 32'(count), 32'(0));
        check("s2_valid", 32'(out_valid), 32'(0));
        check("s2_ferr", 32'(frame_err), 32'(0));

        // Scenario 3: bad stop bit
        send_byte(8'h55, 1'b0);
        idle_bits(1);
        @(negedge clk);
        check("s3_ferr", 32'(frame_err), 32'(1));
        check("s3_count", 32'(count), 32'(0));
        pulse_clr();
        check("s3_clr", 32'(frame_err), 32'(0));

        // Held-low break: one framing error only
        rxd = 1'b0;
        #(30 * bit_t);
        @(negedge clk);
        check("brk_ferr", 32'(frame_err), 32'(1));
        check("brk_state", 32'(dut.state), 32'(RX_WAIT_IDLE));
        pulse_clr();
        #(15 * bit_t);
        @(negedge clk);
        check("brk_once", 32'(frame_err), 32'(0));
        idle_bits(2);
        @(negedge clk);
        check("brk_idle_ferr", 32'(frame_err), 32'(0));
        check("brk_count", 32'(count), 32'(0));

        // Scenario 4: overflow by one
        for (int i = 0; i < 17; i++) send_byte(8'(i), 1'b1);
        idle_bits(1);
        @(negedge clk);
        check("s4_count", 32'(count), 32'(16));
        check("s4_ovr", 32'(overrun), 32'(1));
        for (int i = 0; i < 16; i++) pop_expect(8'(i), "s4_drain");
        check("s4_empty", 32'(count), 32'(0));
        check("s4_nvalid", 32'(out_valid), 32'(0));
        pulse_clr();
        check("s4_clr", 32'(overrun), 32'(0));

        // Scenario 5: pop and push together while full
        for (int i = 0; i < 16; i++) send_byte(8'h20 + 8'(i), 1'b1);
        idle_bits(1);
        @(negedge clk);
        check("s5_full", 32'(count), 32'(16));
        fork
            send_byte(8'h99, 1'b1);
            begin
                n = 0;
                while (n < 2000) begin
                    @(negedge clk);
                    if (dut.push) break;
                    n++;
                end
                check("s5_push_seen", 32'(n < 2000), 32'(1));
                out_ready = 1'b1;
                @(negedge clk);
                out_ready = 1'b0;
                check("s5_count_same", 32'(count), 32'(16));
            end
        join
        idle_bits(1);
        @(negedge clk);
        check("s5_count", 32'(count), 32'(16));
        check("s5_ovr", 32'(overrun), 32'(0));
        for (int i = 1; i < 16; i++) pop_expect(8'h20 + 8'(i), "s5_drain");
        pop_expect(8'h99, "s5_last");
        check("s5_empty", 32'(count), 32'(0));

        // Scenario 6: reset in the middle of data bit 4
        b = 8'h3C;
        rxd = 1'b0;
        #(bit_t);
        for (int i = 0; i < 4; i++) begin
            rxd = b[i];
            #(bit_t);
        end
        rxd = b[4];
        #(bit_t / 2);
        @(negedge clk);
        rst = 1'b1;
        rxd = 1'b1;
        repeat (3) @(negedge clk);
        check("s6_rst_state", 32'(dut.state), 32'(RX_IDLE));
        rst = 1'b0;
        idle_bits(2);
        send_byte(8'hA5, 1'b1);
        idle_bits(1);
        @(negedge clk);
        check("s6_count", 32'(count), 32'(1));
        check("s6_ferr", 32'(frame_err), 32'(0));
        pop_expect(8'hA5, "s6_pop");
        check("s6_empty", 32'(count), 32'(0));

        // Random bursts against a queue model
        for (int r = 0; r < 3; r++) begin
            k = $urandom_range(1, 20);
            exp_q.delete();
            exp_ovr = 1'b0;
            for (int j = 0; j < k; j++) begin
                b = 8'($urandom);
                send_byte(b, 1'b1);
                if (exp_q.size() < 16) exp_q.push_back(b);
                else exp_ovr = 1'b1;
                if ($urandom_range(0, 1) == 1) idle_bits(1);
            end
            idle_bits(1);
            @(negedge clk);
            check("rnd_count", 32'(count), 32'(exp_q.size()));
            check("rnd_ovr", 32'(overrun), 32'(exp_ovr));
            while (exp_q.size() > 0) begin
                repeat ($urandom_range(0, 3)) @(negedge clk);
                pop_expect(exp_q.pop_front(), "rnd_pop");
            end
            check("rnd_empty", 32'(count), 32'(0));
            pulse_clr();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
